// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: decoder-side handshake, RAM read port, run/redirect.
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  run;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_re;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  // Fetch unit side
  modport master (
    input  run, redirect_valid, redirect_pc, imem_rdata, instr_ready,
    output imem_addr, imem_re, instr_valid, instr, instr_pc
  );

  // Environment side (RAM + decoder + control)
  modport slave (
    output run, redirect_valid, redirect_pc, imem_rdata, instr_ready,
    input  imem_addr, imem_re, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, single-cycle RAM read issue, 2-entry {word,pc}
// buffer toward decode, run/halt and redirect with flush.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_ent_t;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  fetch_ent_t [1:0]      fifo_q;   // [0] is head
  logic [1:0]            occ;

  logic                  valid;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            credit_used;
  logic [ADDR_WIDTH-1:0] redirect_target;
  fetch_ent_t            new_ent;

  // Buffered + in-flight words may never exceed the 2 FIFO slots; a pop this
  // cycle frees one, so the issue limit rises by the pop.
  always_comb begin
    credit_used     = {1'b0, occ} + {2'b00, inflight};
    valid           = (occ != 2'd0) && !bus.redirect_valid;
    pop             = valid && bus.instr_ready;
    // rst_n gate keeps imem_re low the instant reset asserts, even with run=1
    issue           = rst_n && bus.run && !bus.redirect_valid &&
                      (credit_used < (3'd2 + {2'b00, pop}));
    push            = inflight && !bus.redirect_valid;
    redirect_target = bus.redirect_pc & ~ADDR_WIDTH'(3);
    new_ent         = '{word: bus.imem_rdata, pc: inflight_pc};
  end

  assign bus.imem_re     = issue;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid;
  assign bus.instr       = fifo_q[0].word;
  assign bus.instr_pc    = fifo_q[0].pc;

  // PC and in-flight tracking; redirect drops any response due next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      pc          <= redirect_target;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_WIDTH'(4);
      end
    end
  end

  // Shift-style 2-entry FIFO; head keeps its last value when the FIFO drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      fifo_q <= '0;
    end else if (bus.redirect_valid) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          fifo_q[occ[0]] <= new_ent;
          occ            <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) fifo_q[0] <= fifo_q[1];
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= new_ent;
          end else begin
            fifo_q[0] <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// checked against a stream-level model (sequential PCs, redirect targets).
module tb_instruction_fetch_unit;

  logic clk;
  logic rst_n0, rst_n1;
  int   n_checks, n_pass;
  logic [31:0] exp_pc, exp_fetch;

  instruction_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
  instruction_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();

  instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0))
    dut0 (.clk(clk), .rst_n(rst_n0), .bus(b0));
  instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8))
    dut1 (.clk(clk), .rst_n(rst_n1), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: word at byte address a is 0x100 + a/4
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  // Synchronous-read RAMs; output 0 when not read
  always @(posedge clk) b0.imem_rdata <= b0.imem_re ? mem_word(b0.imem_addr) : 32'h0;
  always @(posedge clk) b1.imem_rdata <= b1.imem_re ? mem_word(b1.imem_addr) : 32'h0;

  task automatic test_reset();
    rst_n0 = 1'b0;
    b0.run = 1'b1; b0.instr_ready = 1'b1; b0.redirect_valid = 1'b0; b0.redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (b0.imem_re !== 1'b0) $display("FAIL reset_re: got %b expected 0", b0.imem_re); else n_pass++;
    n_checks++; if (b0.imem_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", b0.imem_addr); else n_pass++;
    n_checks++; if (b0.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", b0.instr_valid); else n_pass++;
    n_checks++; if (b0.instr !== 32'h0) $display("FAIL reset_instr: got %h expected 0", b0.instr); else n_pass++;
    n_checks++; if (b0.instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h expected 0", b0.instr_pc); else n_pass++;
    @(posedge clk); #1;
    rst_n0 = 1'b1;
  endtask

  // One issue per cycle from PC 0; first valid two cycles after first issue
  task automatic test_stream();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++; if (b0.imem_re !== 1'b1) $display("FAIL stream_re k=%0d: got %b expected 1", k, b0.imem_re); else n_pass++;
      n_checks++; if (b0.imem_addr !== 32'(4*k)) $display("FAIL stream_addr k=%0d: got %h expected %h", k, b0.imem_addr, 32'(4*k)); else n_pass++;
      n_checks++; if (b0.instr_valid !== (k >= 2)) $display("FAIL stream_valid k=%0d: got %b expected %b", k, b0.instr_valid, (k >= 2)); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (b0.instr_pc !== 32'(4*(k-2))) $display("FAIL stream_pc k=%0d: got %h expected %h", k, b0.instr_pc, 32'(4*(k-2))); else n_pass++;
        n_checks++; if (b0.instr !== 32'h100 + 32'(k-2)) $display("FAIL stream_instr k=%0d: got %h expected %h", k, b0.instr, 32'h100 + 32'(k-2)); else n_pass++;
      end
      @(posedge clk); #1;
    end
    exp_pc = 32'd40; exp_fetch = 32'd48;
  endtask

  // Decoder stalls 5 cycles: reads stop, head holds, stream resumes gap-free
  task automatic test_backpressure();
    b0.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (b0.imem_re !== 1'b0) $display("FAIL bp_re k=%0d: got %b expected 0", k, b0.imem_re); else n_pass++;
      n_checks++; if (b0.instr_valid !== 1'b1) $display("FAIL bp_valid k=%0d: got %b expected 1", k, b0.instr_valid); else n_pass++;
      n_checks++; if (b0.instr_pc !== exp_pc) $display("FAIL bp_hold_pc k=%0d: got %h expected %h", k, b0.instr_pc, exp_pc); else n_pass++;
      @(posedge clk); #1;
    end
    b0.instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (b0.instr_valid !== 1'b1) $display("FAIL bp_resume_valid k=%0d: got %b expected 1", k, b0.instr_valid); else n_pass++;
      n_checks++; if (b0.instr_pc !== exp_pc) $display("FAIL bp_resume_pc k=%0d: got %h expected %h", k, b0.instr_pc, exp_pc); else n_pass++;
      n_checks++; if (b0.instr !== mem_word(exp_pc)) $display("FAIL bp_resume_instr k=%0d: got %h expected %h", k, b0.instr, mem_word(exp_pc)); else n_pass++;
      if (b0.imem_re === 1'b1) begin
        n_checks++; if (b0.imem_addr !== exp_fetch) $display("FAIL bp_resume_addr k=%0d: got %h expected %h", k, b0.imem_addr, exp_fetch); else n_pass++;
        exp_fetch += 4;
      end
      exp_pc += 4;
      @(posedge clk); #1;
    end
  endtask

  // Redirect with ready=1 and a valid head: no handshake, stale words dropped
  task automatic test_redirect(input logic [31:0] target, input bit fill_first);
    logic [31:0] al;
    al = target & 32'hFFFF_FFFC;
    if (fill_first) begin
      b0.instr_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        n_checks++; if (b0.imem_re !== 1'b0) $display("FAIL redir_fill_re k=%0d: got %b expected 0", k, b0.imem_re); else n_pass++;
        @(posedge clk); #1;
      end
    end
    b0.instr_ready = 1'b1; b0.redirect_valid = 1'b1; b0.redirect_pc = target;
    @(negedge clk);
    n_checks++; if (b0.instr_valid !== 1'b0) $display("FAIL redir_valid: got %b expected 0", b0.instr_valid); else n_pass++;
    n_checks++; if (b0.imem_re !== 1'b0) $display("FAIL redir_re: got %b expected 0", b0.imem_re); else n_pass++;
    @(posedge clk); #1;
    b0.redirect_valid = 1'b0; b0.redirect_pc = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (b0.imem_re !== 1'b1) $display("FAIL redir_re R+%0d: got %b expected 1", k, b0.imem_re); else n_pass++;
      n_checks++; if (b0.imem_addr !== al + 32'(4*(k-1))) $display("FAIL redir_addr R+%0d: got %h expected %h", k, b0.imem_addr, al + 32'(4*(k-1))); else n_pass++;
      n_checks++; if (b0.instr_valid !== (k >= 3)) $display("FAIL redir_valid R+%0d: got %b expected %b", k, b0.instr_valid, (k >= 3)); else n_pass++;
      if (k >= 3) begin
        n_checks++; if (b0.instr_pc !== al + 32'(4*(k-3))) $display("FAIL redir_pc R+%0d: got %h expected %h", k, b0.instr_pc, al + 32'(4*(k-3))); else n_pass++;
        n_checks++; if (b0.instr !== mem_word(al + 32'(4*(k-3)))) $display("FAIL redir_instr R+%0d: got %h expected %h", k, b0.instr, mem_word(al + 32'(4*(k-3)))); else n_pass++;
      end
      @(posedge clk); #1;
    end
    exp_pc = al + 32'd8; exp_fetch = al + 32'd16;
  endtask

  // run low 3 cycles: no reads, buffered + in-flight words still delivered
  task automatic test_run_halt();
    int delivered = 0;
    b0.run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (b0.imem_re !== 1'b0) $display("FAIL halt_re k=%0d: got %b expected 0", k, b0.imem_re); else n_pass++;
      if (b0.instr_valid === 1'b1) begin
        n_checks++; if (b0.instr_pc !== exp_pc) $display("FAIL halt_pc k=%0d: got %h expected %h", k, b0.instr_pc, exp_pc); else n_pass++;
        n_checks++; if (b0.instr !== mem_word(exp_pc)) $display("FAIL halt_instr k=%0d: got %h expected %h", k, b0.instr, mem_word(exp_pc)); else n_pass++;
        exp_pc += 4; delivered++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (delivered != 2) $display("FAIL halt_delivered: got %0d expected 2", delivered); else n_pass++;
    b0.run = 1'b1;
    @(negedge clk);
    n_checks++; if (b0.imem_re !== 1'b1) $display("FAIL resume_re: got %b expected 1", b0.imem_re); else n_pass++;
    n_checks++; if (b0.imem_addr !== exp_pc) $display("FAIL resume_addr: got %h expected %h", b0.imem_addr, exp_pc); else n_pass++;
    exp_fetch = exp_pc + 32'd4;
    @(posedge clk); #1;
  endtask

  // Random run/ready/redirect against a stream model: accepted PCs are
  // sequential from the last redirect target, reads are sequential, at most
  // two words outstanding, and three clean cycles guarantee a valid word.
  task automatic test_random();
    int streak = 0;
    logic rdy, rn, rd, re_s, acc_s;
    logic [31:0] rpc;
    for (int c = 0; c < 500; c++) begin
      rdy = ($urandom % 10) < 7;
      rn  = ($urandom % 10) < 8;
      rd  = ($urandom % 25) == 0;
      rpc = $urandom;
      b0.instr_ready = rdy; b0.run = rn; b0.redirect_valid = rd; b0.redirect_pc = rpc;
      @(negedge clk);
      re_s  = b0.imem_re;
      acc_s = b0.instr_valid & rdy;
      if (rd) begin
        n_checks++; if (b0.instr_valid !== 1'b0) $display("FAIL rnd_redir_valid c=%0d: got %b expected 0", c, b0.instr_valid); else n_pass++;
        n_checks++; if (b0.imem_re !== 1'b0) $display("FAIL rnd_redir_re c=%0d: got %b expected 0", c, b0.imem_re); else n_pass++;
      end else begin
        if (re_s === 1'b1) begin
          n_checks++; if (b0.imem_addr !== exp_fetch) $display("FAIL rnd_addr c=%0d: got %h expected %h", c, b0.imem_addr, exp_fetch); else n_pass++;
        end
        if (acc_s === 1'b1) begin
          n_checks++; if (b0.instr_pc !== exp_pc) $display("FAIL rnd_pc c=%0d: got %h expected %h", c, b0.instr_pc, exp_pc); else n_pass++;
          n_checks++; if (b0.instr !== mem_word(exp_pc)) $display("FAIL rnd_instr c=%0d: got %h expected %h", c, b0.instr, mem_word(exp_pc)); else n_pass++;
        end
      end
      streak = (rn && rdy && !rd) ? streak + 1 : 0;
      if (streak >= 3) begin
        n_checks++; if (b0.instr_valid !== 1'b1) $display("FAIL rnd_throughput c=%0d: got %b expected 1", c, b0.instr_valid); else n_pass++;
      end
      @(posedge clk); #1;
      if (rd) begin
        exp_pc = rpc & 32'hFFFF_FFFC; exp_fetch = exp_pc;
      end else begin
        if (re_s === 1'b1) exp_fetch += 4;
        if (acc_s === 1'b1) exp_pc += 4;
      end
      n_checks++; if (exp_fetch - exp_pc > 32'd8) $display("FAIL rnd_outstanding c=%0d: got %0d expected <=2", c, (exp_fetch - exp_pc) >> 2); else n_pass++;
    end
    b0.redirect_valid = 1'b0; b0.run = 1'b1; b0.instr_ready = 1'b1;
  endtask

  // PC wrap from 0xFFFF_FFF8 and asynchronous reset mid-stream
  task automatic test_wrap();
    logic [31:0] a;
    b1.run = 1'b0; b1.instr_ready = 1'b1; b1.redirect_valid = 1'b0; b1.redirect_pc = '0;
    rst_n1 = 1'b0;
    @(negedge clk);
    n_checks++; if (b1.imem_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_reset_addr: got %h expected fffffff8", b1.imem_addr); else n_pass++;
    n_checks++; if (b1.imem_re !== 1'b0) $display("FAIL wrap_reset_re: got %b expected 0", b1.imem_re); else n_pass++;
    @(posedge clk); #1;
    rst_n1 = 1'b1; b1.run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 32'hFFFF_FFF8 + 32'(4*k);
      @(negedge clk);
      n_checks++; if (b1.imem_re !== 1'b1) $display("FAIL wrap_re k=%0d: got %b expected 1", k, b1.imem_re); else n_pass++;
      n_checks++; if (b1.imem_addr !== a) $display("FAIL wrap_addr k=%0d: got %h expected %h", k, b1.imem_addr, a); else n_pass++;
      if (k >= 2) begin
        a = 32'hFFFF_FFF8 + 32'(4*(k-2));
        n_checks++; if (b1.instr_valid !== 1'b1) $display("FAIL wrap_valid k=%0d: got %b expected 1", k, b1.instr_valid); else n_pass++;
        n_checks++; if (b1.instr_pc !== a) $display("FAIL wrap_pc k=%0d: got %h expected %h", k, b1.instr_pc, a); else n_pass++;
        n_checks++; if (b1.instr !== mem_word(a)) $display("FAIL wrap_instr k=%0d: got %h expected %h", k, b1.instr, mem_word(a)); else n_pass++;
      end
      @(posedge clk); #1;
    end
    rst_n1 = 1'b0;
    #1;
    n_checks++; if (b1.imem_re !== 1'b0) $display("FAIL async_rst_re: got %b expected 0", b1.imem_re); else n_pass++;
    n_checks++; if (b1.imem_addr !== 32'hFFFF_FFF8) $display("FAIL async_rst_addr: got %h expected fffffff8", b1.imem_addr); else n_pass++;
    n_checks++; if (b1.instr_valid !== 1'b0) $display("FAIL async_rst_valid: got %b expected 0", b1.instr_valid); else n_pass++;
    n_checks++; if (b1.instr !== 32'h0) $display("FAIL async_rst_instr: got %h expected 0", b1.instr); else n_pass++;
    n_checks++; if (b1.instr_pc !== 32'h0) $display("FAIL async_rst_pc: got %h expected 0", b1.instr_pc); else n_pass++;
    @(posedge clk); #1;
    b1.run = 1'b0; rst_n1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (b1.instr_valid !== 1'b0) $display("FAIL post_rst_valid k=%0d: got %b expected 0", k, b1.instr_valid); else n_pass++;
      n_checks++; if (b1.imem_re !== 1'b0) $display("FAIL post_rst_re k=%0d: got %b expected 0", k, b1.imem_re); else n_pass++;
      @(posedge clk); #1;
    end
    b1.run = 1'b1;
    @(negedge clk);
    n_checks++; if (b1.imem_addr !== 32'hFFFF_FFF8) $display("FAIL post_rst_addr: got %h expected fffffff8", b1.imem_addr); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0;
    exp_pc = '0; exp_fetch = '0;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    b0.run = 1'b0; b0.instr_ready = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_pc = '0;
    b1.run = 1'b0; b1.instr_ready = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(32'h0000_002A, 1'b0);
    test_redirect(32'h0000_1003, 1'b1);
    test_run_halt();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
